// File: rtl/pspin_stdout_fifo_pkg.sv
// Shared definitions for the PsPIN stdout FIFO slice.
// Contents: word width, default depth, word type and an index-width helper
// used by the arbiter to size its grant-index register.
package pspin_stdout_pkg;

  localparam int STDOUT_WORD_WIDTH = 32;
  localparam int STDOUT_FIFO_DEPTH = 1024;

  typedef logic [STDOUT_WORD_WIDTH-1:0] stdout_word_t;

  // Bits needed to hold an index 0..n-1; a single port still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pspin_stdout_fifo_if.sv
// Bundle of the cluster writer ports and the register-block read side.
// master: writers + register block (drive wr_valid/wr_data/stdout_rd_en).
// slave : the FIFO (drives wr_ready, stdout_dout, stdout_data_valid,
//         fill_level, pop_underflow).
interface pspin_stdout_fifo_if
  import pspin_stdout_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = STDOUT_FIFO_DEPTH
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [NUM_PORTS-1:0]                   wr_valid;
  logic [NUM_PORTS*STDOUT_WORD_WIDTH-1:0] wr_data;
  logic [NUM_PORTS-1:0]                   wr_ready;
  logic                                   stdout_rd_en;
  stdout_word_t                           stdout_dout;
  logic                                   stdout_data_valid;
  logic [PTR_WIDTH:0]                     fill_level;
  logic                                   pop_underflow;

  modport master (
    output wr_valid, wr_data, stdout_rd_en,
    input  wr_ready, stdout_dout, stdout_data_valid, fill_level, pop_underflow
  );

  modport slave (
    input  wr_valid, wr_data, stdout_rd_en,
    output wr_ready, stdout_dout, stdout_data_valid, fill_level, pop_underflow
  );

endinterface

// File: rtl/pspin_stdout_fifo_rr_arb.sv
// Round-robin arbiter (module pspin_rr_arb).
// Ports: clk, rst_n (async, active-low), req (per-port request),
//        advance (a granted request was accepted), grant (one-hot, combinational).
// The search starts one past the last accepted port; after reset the last
// port is NUM_PORTS-1 so port 0 wins the first round.
module pspin_rr_arb
  import pspin_stdout_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant
);

  localparam int IW = idx_width(NUM_PORTS);
  localparam logic [IW-1:0] LAST_PORT = IW'(NUM_PORTS - 1);

  logic [IW-1:0] last_grant_reg;
  logic [IW-1:0] grant_idx;
  logic          grant_found;
  int            scan_idx;

  always_comb begin
    grant       = '0;
    grant_idx   = last_grant_reg;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      // last_grant < NUM_PORTS and k <= NUM_PORTS, so one subtraction wraps.
      scan_idx = int'(last_grant_reg) + k;
      if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
      if (!grant_found && req[IW'(scan_idx)]) begin
        grant_found            = 1'b1;
        grant[IW'(scan_idx)]   = 1'b1;
        grant_idx              = IW'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= LAST_PORT;
    end else if (advance && grant_found) begin
      last_grant_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/pspin_stdout_fifo.sv
// PsPIN stdout FIFO: merges per-cluster stdout writers through a round-robin
// arbiter into one circular buffer with first-word-fall-through readout.
// Ports: clk, rst_n (async assert, active-low), bus (slave side of
// pspin_stdout_fifo_if: wr_valid/wr_data/wr_ready per port, stdout_rd_en pop
// strobe, stdout_dout head word, stdout_data_valid, fill_level, sticky
// pop_underflow).
module pspin_stdout_fifo
  import pspin_stdout_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DEPTH      = STDOUT_FIFO_DEPTH,
  parameter int DATA_WIDTH = STDOUT_WORD_WIDTH,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  pspin_stdout_fifo_if.slave   bus
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_reg;
  logic [PTR_WIDTH-1:0]  rd_ptr_reg;
  logic [PTR_WIDTH:0]    count_reg;
  logic                  underflow_reg;

  logic [NUM_PORTS-1:0]  grant;
  logic [NUM_PORTS-1:0]  wr_ready_int;
  logic [DATA_WIDTH-1:0] push_word;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  pspin_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.wr_valid),
    .advance (push),
    .grant   (grant)
  );

  // Ready is held low during reset so no writer sees a phantom accept.
  // While full nobody is accepted, even if a pop lands in the same cycle.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign wr_ready_int[gi] = rst_n && grant[gi] && !full;
    end
  endgenerate

  always_comb begin
    push_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) push_word = push_word | bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign push = |(bus.wr_valid & wr_ready_int);
  assign pop  = bus.stdout_rd_en && !empty;

  // Storage carries no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      underflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
      if (bus.stdout_rd_en && empty) underflow_reg <= 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_WIDTH + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_WIDTH + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign bus.wr_ready          = wr_ready_int;
  assign bus.stdout_data_valid = !empty;
  assign bus.stdout_dout       = empty ? '0 : mem[rd_ptr_reg];
  assign bus.fill_level        = count_reg;
  assign bus.pop_underflow     = underflow_reg;

endmodule

// File: tb/tb_pspin_stdout_fifo.sv
// Self-checking bench for pspin_stdout_fifo (2 ports, DEPTH 4).
// Reference model: a word queue, an integer last-grant index and a sticky
// underflow bit, updated from the writer/pop rules each cycle.
module tb_pspin_stdout_fifo;
  import pspin_stdout_pkg::*;

  localparam int NP = 2;
  localparam int D  = 4;

  logic clk;
  logic rst_n;

  pspin_stdout_fifo_if #(.NUM_PORTS(NP), .DEPTH(D)) bus ();

  pspin_stdout_fifo #(.NUM_PORTS(NP), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [31:0] model_q[$];
  int          m_last;
  bit          m_unf;
  // writer drivers
  logic [31:0] pend[NP][$];
  bit          presenting[NP];
  bit          rand_gate;
  logic [31:0] popped[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rd);
    logic [NP-1:0] exp_ready;
    int            gidx;
    logic [31:0]   w;
    int            pre_size;
    for (int i = 0; i < NP; i++) begin
      if (!presenting[i] && pend[i].size() > 0)
        presenting[i] = rand_gate ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.wr_valid[i] = presenting[i];
      bus.wr_data[i*32 +: 32] = (pend[i].size() > 0) ? pend[i][0] : 32'h0;
    end
    bus.stdout_rd_en = rd;
    #1;
    pre_size = model_q.size();
    check_eq("dout",  bus.stdout_dout, (pre_size != 0) ? model_q[0] : 32'h0);
    check_eq("valid", bus.stdout_data_valid, pre_size != 0);
    check_eq("fill",  bus.fill_level, pre_size);
    check_eq("unf",   bus.pop_underflow, m_unf);
    exp_ready = '0;
    gidx = -1;
    if (pre_size != D) begin
      for (int k = 1; k <= NP; k++) begin
        int idx;
        idx = (m_last + k) % NP;
        if (gidx < 0 && presenting[idx]) gidx = idx;
      end
      if (gidx >= 0) exp_ready[gidx] = 1'b1;
    end
    check_eq("wr_ready", bus.wr_ready, exp_ready);
    check_eq("rdy_onehot", $onehot0(bus.wr_ready), 1);
    if (rd) begin
      if (pre_size == 0) m_unf = 1'b1;
      else begin
        popped.push_back(bus.stdout_dout);
        void'(model_q.pop_front());
      end
    end
    if (gidx >= 0) begin
      w = pend[gidx].pop_front();
      model_q.push_back(w);
      m_last = gidx;
      presenting[gidx] = 1'b0;
    end
    if (gidx >= 0 || rd)
      $display("t=%0t push=%0d port=%0d word=%h pop=%0d fill_next=%0d",
               $time, gidx >= 0, gidx, (gidx >= 0) ? w : 32'h0, rd && pre_size != 0, model_q.size());
    @(negedge clk);
  endtask

  // Assert reset mid-stream with writers requesting; all outputs must clear.
  task automatic do_reset();
    bus.wr_valid = '1;
    bus.stdout_rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready", bus.wr_ready, 0);
    check_eq("rst_dout",  bus.stdout_dout, 0);
    check_eq("rst_valid", bus.stdout_data_valid, 0);
    check_eq("rst_fill",  bus.fill_level, 0);
    check_eq("rst_unf",   bus.pop_underflow, 0);
    model_q.delete();
    popped.delete();
    m_last = NP - 1;
    m_unf = 1'b0;
    for (int i = 0; i < NP; i++) begin
      pend[i].delete();
      presenting[i] = 1'b0;
    end
    bus.wr_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_rr[6];
    int          bound;
    rst_n = 1'b0;
    rand_gate = 1'b0;
    bus.wr_valid = '0;
    bus.wr_data = '0;
    bus.stdout_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Underflow on empty FIFO, sticky afterwards.
    step(1);
    step(0);
    check_eq("unf_set",  bus.pop_underflow, 1);
    check_eq("unf_dout", bus.stdout_dout, 0);
    step(0);
    check_eq("unf_sticky", bus.pop_underflow, 1);
    do_reset();

    // First write after reset.
    pend[0].push_back(32'hDEADBEEF);
    step(0);
    check_eq("db_dout",  bus.stdout_dout, 32'hDEADBEEF);
    check_eq("db_valid", bus.stdout_data_valid, 1);
    do_reset();

    // Round-robin ordering.
    for (int i = 0; i < 3; i++) begin
      pend[0].push_back(32'hA0 + i);
      pend[1].push_back(32'hB0 + i);
    end
    exp_rr = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
    for (int c = 0; c < 12; c++) step(model_q.size() != 0);
    check_eq("rr_count", popped.size(), 6);
    for (int i = 0; i < 6; i++)
      check_eq("rr_order", (i < popped.size()) ? popped[i] : 32'hX, exp_rr[i]);
    do_reset();

    // Full: writer keeps requesting, pop frees one slot.
    for (int i = 0; i < 6; i++) pend[0].push_back(32'h100 + i);
    repeat (5) step(0);
    check_eq("full_fill",  bus.fill_level, 4);
    check_eq("full_ready", bus.wr_ready, 0);
    step(1);
    check_eq("full_after_pop", bus.fill_level, 3);
    step(0);
    check_eq("full_refill", bus.fill_level, 4);
    check_eq("full_head", bus.stdout_dout, 32'h101);
    do_reset();

    // Wrap-around: 10 words through a 4-deep buffer.
    for (int i = 0; i < 10; i++) pend[0].push_back(32'h200 + i);
    bound = 0;
    while (popped.size() < 10 && bound < 60) begin
      step(model_q.size() >= 2 || pend[0].size() == 0);
      bound++;
    end
    check_eq("wrap_count", popped.size(), 10);
    for (int i = 0; i < 10; i++)
      check_eq("wrap_order", (i < popped.size()) ? popped[i] : 32'hX, 32'h200 + i);
    do_reset();

    // Simultaneous push/pop at count 1 and at count 0.
    pend[0].push_back(32'h300);
    step(0);
    pend[0].push_back(32'h301);
    step(1);
    check_eq("pp1_fill", bus.fill_level, 1);
    check_eq("pp1_dout", bus.stdout_dout, 32'h301);
    check_eq("pp1_unf",  bus.pop_underflow, 0);
    step(1);
    check_eq("pp_empty", bus.fill_level, 0);
    pend[0].push_back(32'h302);
    step(1);
    check_eq("pp0_fill", bus.fill_level, 1);
    check_eq("pp0_unf",  bus.pop_underflow, 1);
    check_eq("pp0_dout", bus.stdout_dout, 32'h302);
    do_reset();

    // Randomized traffic with varying pop pressure and mid-stream resets.
    rand_gate = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < NP; i++)
          if (pend[i].size() < 3 && $urandom_range(0, 2) == 0) pend[i].push_back($urandom);
        case (r)
          0:       step($urandom_range(0, 1) == 1);
          1:       step($urandom_range(0, 3) == 0);
          default: step($urandom_range(0, 3) != 0);
        endcase
      end
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
